operand_read_stage: RTL and testbench

Issue-side reader for the 2-read/4-write physical register file. Accepts one issued instruction per cycle, drives the file's two read ports, bypasses any same-cycle writeback data, and registers both operands plus a pass-through tag into a single valid/ready output slot for the execute stage. It sits between the issue queue and the functional units. It is the consumer of the register file's read interface, which its write ports feed.

---
 rtl/operand_read_stage.sv | 126 ++++++++++++
 tb/tb_operand_read_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_read_stage.sv
// Operand read stage: drives the register file read ports, bypasses same-cycle
// writebacks and registers both operands plus a tag into one valid/ready slot.
module operand_read_stage #(
  parameter int OPRAND_WIDTH  = 32,
  parameter int REGNAME_WIDTH = 5,
  parameter int TAG_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [REGNAME_WIDTH-1:0] issue_rs1_i,
  input  logic [REGNAME_WIDTH-1:0] issue_rs2_i,
  input  logic                     issue_rs1_use_i,
  input  logic                     issue_rs2_use_i,
  input  logic [TAG_WIDTH-1:0]     issue_tag_i,
  output logic [REGNAME_WIDTH-1:0] read1_addr_o,
  output logic [REGNAME_WIDTH-1:0] read2_addr_o,
  output logic                     read1_en_o,
  output logic                     read2_en_o,
  input  logic [OPRAND_WIDTH-1:0]  read1_data_i,
  input  logic [OPRAND_WIDTH-1:0]  read2_data_i,
  input  logic                     read1_ready_i,
  input  logic                     read2_ready_i,
  input  logic                     write11_en_i,
  input  logic                     write12_en_i,
  input  logic                     write21_en_i,
  input  logic                     write22_en_i,
  input  logic [REGNAME_WIDTH-1:0] write11_addr_i,
  input  logic [REGNAME_WIDTH-1:0] write12_addr_i,
  input  logic [REGNAME_WIDTH-1:0] write21_addr_i,
  input  logic [REGNAME_WIDTH-1:0] write22_addr_i,
  input  logic [OPRAND_WIDTH-1:0]  write11_data_i,
  input  logic [OPRAND_WIDTH-1:0]  write12_data_i,
  input  logic [OPRAND_WIDTH-1:0]  write21_data_i,
  input  logic [OPRAND_WIDTH-1:0]  write22_data_i,
  input  logic                     flush_i,
  output logic                     ex_valid_o,
  input  logic                     ex_ready_i,
  output logic [OPRAND_WIDTH-1:0]  ex_op1_o,
  output logic [OPRAND_WIDTH-1:0]  ex_op2_o,
  output logic [TAG_WIDTH-1:0]     ex_tag_o
);

  logic                    slot_free;
  logic                    accept;
  logic                    rs1_live;
  logic                    rs2_live;
  logic                    op1_ok;
  logic                    op2_ok;
  logic [OPRAND_WIDTH-1:0] op1_val;
  logic [OPRAND_WIDTH-1:0] op2_val;

  assign slot_free = !ex_valid_o || ex_ready_i;
  assign rs1_live  = issue_rs1_use_i && (issue_rs1_i != '0);
  assign rs2_live  = issue_rs2_use_i && (issue_rs2_i != '0);

  assign read1_addr_o = issue_rs1_i;
  assign read2_addr_o = issue_rs2_i;
  assign read1_en_o   = issue_valid_i && rs1_live && slot_free && !flush_i && !rst;
  assign read2_en_o   = issue_valid_i && rs2_live && slot_free && !flush_i && !rst;

  // The file's ready only matters when neither x0 nor a bypass supplies the value.
  always_comb begin
    op1_val = '0;
    op1_ok  = 1'b1;
    if (!rs1_live) begin
      op1_val = '0;
    end else if (write22_en_i && (write22_addr_i == issue_rs1_i)) begin
      op1_val = write22_data_i;
    end else if (write21_en_i && (write21_addr_i == issue_rs1_i)) begin
      op1_val = write21_data_i;
    end else if (write12_en_i && (write12_addr_i == issue_rs1_i)) begin
      op1_val = write12_data_i;
    end else if (write11_en_i && (write11_addr_i == issue_rs1_i)) begin
      op1_val = write11_data_i;
    end else begin
      op1_val = read1_data_i;
      op1_ok  = read1_ready_i;
    end
  end

  always_comb begin
    op2_val = '0;
    op2_ok  = 1'b1;
    if (!rs2_live) begin
      op2_val = '0;
    end else if (write22_en_i && (write22_addr_i == issue_rs2_i)) begin
      op2_val = write22_data_i;
    end else if (write21_en_i && (write21_addr_i == issue_rs2_i)) begin
      op2_val = write21_data_i;
    end else if (write12_en_i && (write12_addr_i == issue_rs2_i)) begin
      op2_val = write12_data_i;
    end else if (write11_en_i && (write11_addr_i == issue_rs2_i)) begin
      op2_val = write11_data_i;
    end else begin
      op2_val = read2_data_i;
      op2_ok  = read2_ready_i;
    end
  end

  assign issue_ready_o = slot_free && op1_ok && op2_ok && !flush_i && !rst;
  assign accept        = issue_valid_i && issue_ready_o;

  // Flush only kills the valid bit; operand and tag registers keep their contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_o <= 1'b0;
      ex_op1_o   <= '0;
      ex_op2_o   <= '0;
      ex_tag_o   <= '0;
    end else begin
      if (flush_i) begin
        ex_valid_o <= 1'b0;
      end else if (accept) begin
        ex_valid_o <= 1'b1;
        ex_op1_o   <= op1_val;
        ex_op2_o   <= op2_val;
        ex_tag_o   <= issue_tag_i;
      end else if (ex_ready_i) begin
        ex_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_read_stage.sv
// Bench for operand_read_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based slot model.
module tb_operand_read_stage;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  rs1, rs2;
  logic        use1, use2;
  logic [7:0]  tag;
  logic [4:0]  rd1_addr, rd2_addr;
  logic        rd1_en, rd2_en;
  logic [31:0] rd1_data, rd2_data;
  logic        rd1_ready, rd2_ready;
  logic        w_en[4];
  logic [4:0]  w_addr[4];
  logic [31:0] w_data[4];
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_op1, ex_op2;
  logic [7:0]  ex_tag;

  logic [31:0] regs[32];
  int          tests = 0;
  int          fails = 0;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [7:0]  tag;
  } slot_t;

  slot_t q[$];
  slot_t last = '0;

  operand_read_stage dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_rs1_i(rs1), .issue_rs2_i(rs2),
    .issue_rs1_use_i(use1), .issue_rs2_use_i(use2),
    .issue_tag_i(tag),
    .read1_addr_o(rd1_addr), .read2_addr_o(rd2_addr),
    .read1_en_o(rd1_en), .read2_en_o(rd2_en),
    .read1_data_i(rd1_data), .read2_data_i(rd2_data),
    .read1_ready_i(rd1_ready), .read2_ready_i(rd2_ready),
    .write11_en_i(w_en[0]), .write12_en_i(w_en[1]),
    .write21_en_i(w_en[2]), .write22_en_i(w_en[3]),
    .write11_addr_i(w_addr[0]), .write12_addr_i(w_addr[1]),
    .write21_addr_i(w_addr[2]), .write22_addr_i(w_addr[3]),
    .write11_data_i(w_data[0]), .write12_data_i(w_data[1]),
    .write21_data_i(w_data[2]), .write22_data_i(w_data[3]),
    .flush_i(flush),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .ex_op1_o(ex_op1), .ex_op2_o(ex_op2), .ex_tag_o(ex_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file stand-in: combinational read, writes land at the edge.
  assign rd1_data = regs[rs1];
  assign rd2_data = regs[rs2];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (w_en[i]) regs[w_addr[i]] <= w_data[i];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ports are scanned in ascending priority so the highest-priority hit overwrites.
  function automatic void model_operand(input logic u, input logic [4:0] rs, input logic rdy,
                                        output logic [31:0] val, output logic ok);
    logic hit;
    hit = 1'b0;
    val = '0;
    ok  = 1'b1;
    if (u && rs != 5'd0) begin
      for (int i = 0; i < 4; i++)
        if (w_en[i] && w_addr[i] == rs) begin
          hit = 1'b1;
          val = w_data[i];
        end
      if (!hit) begin
        val = regs[rs];
        ok  = rdy;
      end
    end
  endfunction

  function automatic void model_comb(output logic rdy, output logic e1, output logic e2,
                                     output logic [31:0] v1, output logic [31:0] v2);
    logic ok1, ok2, free;
    model_operand(use1, rs1, rd1_ready, v1, ok1);
    model_operand(use2, rs2, rd2_ready, v2, ok2);
    free = (q.size() == 0) || ex_ready;
    rdy  = free && ok1 && ok2 && !flush && !rst;
    e1   = issue_valid && use1 && rs1 != 5'd0 && free && !flush && !rst;
    e2   = issue_valid && use2 && rs2 != 5'd0 && free && !flush && !rst;
  endfunction

  always @(posedge clk) begin
    logic rdy, e1, e2;
    logic [31:0] v1, v2;
    if (!rst) begin
      model_comb(rdy, e1, e2, v1, v2);
      if (flush) begin
        q.delete();
      end else if (issue_valid && rdy) begin
        q.delete();
        last = '{op1: v1, op2: v2, tag: tag};
        q.push_back(last);
      end else if (ex_ready && q.size() != 0) begin
        void'(q.pop_front());
      end
    end
  end

  always @(posedge rst) begin
    q.delete();
    last = '0;
  end

  always @(negedge clk) begin
    logic rdy, e1, e2;
    logic [31:0] v1, v2;
    if (!rst) begin
      model_comb(rdy, e1, e2, v1, v2);
      checkOutput("issue_ready", {31'd0, issue_ready}, {31'd0, rdy});
      checkOutput("read1_en", {31'd0, rd1_en}, {31'd0, e1});
      checkOutput("read2_en", {31'd0, rd2_en}, {31'd0, e2});
      checkOutput("read1_addr", {27'd0, rd1_addr}, {27'd0, rs1});
      checkOutput("read2_addr", {27'd0, rd2_addr}, {27'd0, rs2});
      checkOutput("ex_valid", {31'd0, ex_valid}, {31'd0, q.size() != 0});
      checkOutput("ex_op1", ex_op1, last.op1);
      checkOutput("ex_op2", ex_op2, last.op2);
      checkOutput("ex_tag", {24'd0, ex_tag}, {24'd0, last.tag});
    end
  end

  task automatic applyStimulus(input logic v, input logic [4:0] a1, input logic u1,
                               input logic [4:0] a2, input logic u2, input logic [7:0] t,
                               input logic r1, input logic r2, input logic er, input logic fl);
    issue_valid = v;
    rs1 = a1; use1 = u1;
    rs2 = a2; use2 = u2;
    tag = t;
    rd1_ready = r1; rd2_ready = r2;
    ex_ready = er;
    flush = fl;
    for (int i = 0; i < 4; i++) begin
      w_en[i] = 1'b0; w_addr[i] = '0; w_data[i] = '0;
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pre[32];
    int slot;
    rst = 1'b1;
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    checkOutput("rst_read1_en", {31'd0, rd1_en}, 32'd0);
    checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("rst_ex_op1", ex_op1, 32'd0);
    checkOutput("rst_ex_op2", ex_op2, 32'd0);
    checkOutput("rst_ex_tag", {24'd0, ex_tag}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

    // Preload r1..r31 through the write ports, four per cycle.
    for (int r = 1; r < 32; r++) pre[r] = $urandom;
    pre[5] = 32'h1111_0000; pre[6] = 32'h0000_2222; pre[12] = 32'h0C0C_0C0C;
    slot = 0;
    for (int r = 1; r < 32; r++) begin
      w_en[slot] = 1'b1; w_addr[slot] = 5'(r); w_data[slot] = pre[r];
      slot++;
      if (slot == 4 || r == 31) begin
        stepCycle();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        slot = 0;
      end
    end

    // Basic read
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    stepCycle();
    checkOutput("basic_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("basic_op1", ex_op1, 32'h1111_0000);
    checkOutput("basic_op2", ex_op2, 32'h0000_2222);
    checkOutput("basic_tag", {24'd0, ex_tag}, 32'h3C);

    // x0 and unused operand need no ready
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd7, 1'b0, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("x0_ready", {31'd0, issue_ready}, 32'd1);
    checkOutput("x0_read1_en", {31'd0, rd1_en}, 32'd0);
    checkOutput("x0_read2_en", {31'd0, rd2_en}, 32'd0);
    stepCycle();
    checkOutput("x0_op1", ex_op1, 32'd0);
    checkOutput("x0_op2", ex_op2, 32'd0);

    // Bypass priority: write22 beats write11
    applyStimulus(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 8'h09, 1'b0, 1'b0, 1'b1, 1'b0);
    w_en[0] = 1'b1; w_addr[0] = 5'd9; w_data[0] = 32'h0000_AAAA;
    w_en[3] = 1'b1; w_addr[3] = 5'd9; w_data[3] = 32'h0000_BBBB;
    #1;
    checkOutput("byp_ready", {31'd0, issue_ready}, 32'd1);
    stepCycle();
    checkOutput("byp_op1", ex_op1, 32'h0000_BBBB);

    // Backpressure: held slot ignores later writes to its source register
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    stepCycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0);
      if (c == 1) begin
        w_en[1] = 1'b1; w_addr[1] = 5'd5; w_data[1] = 32'hDEAD_0005;
      end
      #1;
      checkOutput("bp_issue_ready", {31'd0, issue_ready}, 32'd0);
      stepCycle();
      checkOutput("bp_valid", {31'd0, ex_valid}, 32'd1);
      checkOutput("bp_op1", ex_op1, 32'h1111_0000);
      checkOutput("bp_tag", {24'd0, ex_tag}, 32'h55);
    end
    applyStimulus(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("bp_release_ready", {31'd0, issue_ready}, 32'd1);
    stepCycle();
    checkOutput("bp_next_op1", ex_op1, 32'h0000_2222);
    checkOutput("bp_next_tag", {24'd0, ex_tag}, 32'h66);

    // Read-ready stall on operand 2
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput("rs_stall_ready", {31'd0, issue_ready}, 32'd0);
      stepCycle();
    end
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 8'h77, 1'b1, 1'b1, 0, 1'b0);
    #1;
    checkOutput("rs_go_ready", {31'd0, issue_ready}, 32'd1);
    stepCycle();
    checkOutput("rs_op2", ex_op2, 32'h0C0C_0C0C);
    checkOutput("rs_tag", {24'd0, ex_tag}, 32'h77);

    // Flush kills the held slot and blocks a simultaneous issue
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 8'h88, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("flush_ready", {31'd0, issue_ready}, 32'd0);
    stepCycle();
    checkOutput("flush_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flush_tag", {24'd0, ex_tag}, 32'h77);

    // Asynchronous reset between edges
    applyStimulus(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("async_rst_tag", {24'd0, ex_tag}, 32'd0);
    rst = 1'b0;
    stepCycle();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom),
                    $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      for (int i = 0; i < 4; i++) begin
        w_en[i]   = $urandom_range(0, 2) == 0;
        w_addr[i] = 5'($urandom_range(0, 7));
        w_data[i] = $urandom;
      end
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
